// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//
// Write-access scheduler for a shared bank of edge-triggered DFF registers.
// Requests from N_REQ requesters are granted round-robin. The winner's address
// and data are captured, then the bank write port is driven through a fixed
// SETUP -> STROBE -> HOLD sequence. This keeps bank_A/bank_D stable one cycle
// before and one cycle after the bank_E pulse.
//
// Parameters:
//   N_REQ   number of requesters (2..8)
//   WIDTH   data width of each bank register
//   ADDR_W  bank address width (bank depth 2**ADDR_W)
//
// Ports:
//   C       in   clock, rising-edge active
//   R       in   reset, asynchronous, active-high
//   req     in   per-requester write request (level)
//   req_A   in   per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   req_D   in   per-requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt     out  one-hot grant pulse, high during SETUP only
//   bank_A  out  bank write address
//   bank_D  out  bank write data
//   bank_E  out  bank write enable, high during STROBE only
//   busy    out  high whenever the scheduler is not idle

module dff_bank_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 2
) (
   input  logic                    C,
   input  logic                    R,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_A,
   input  logic [N_REQ*WIDTH-1:0]  req_D,
   output logic [N_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]       bank_A,
   output logic [WIDTH-1:0]        bank_D,
   output logic                    bank_E,
   output logic                    busy
);

   localparam int unsigned LastW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [LastW-1:0] LastRst = LastW'(N_REQ - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StHold
   } state_e;

   state_e              state_q, state_d;
   logic [LastW-1:0]    last_q, last_d;
   logic [ADDR_W-1:0]   bank_a_q, bank_a_d;
   logic [WIDTH-1:0]    bank_d_q, bank_d_d;

   // Round-robin search result.
   logic                win_found;
   logic [LastW-1:0]    win_idx;
   int unsigned         scan_idx;

   // ------------------------------------------------------------------
   // Round-robin arbiter: scan from last+1 upward, wrapping at N_REQ,
   // and take the first set request. The last index scanned is 'last'
   // itself, so a lone requester that just won can win again.
   // ------------------------------------------------------------------
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      scan_idx  = 0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         scan_idx = (int'(last_q) + off) % N_REQ;
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = LastW'(scan_idx);
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Address/data/pointer only move on entry to SETUP,
   // so the bank sees stable D/A across STROBE and HOLD regardless of
   // what the requester does with its slices after the grant.
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      bank_a_d = bank_a_q;
      bank_d_d = bank_d_q;

      case (state_q)
         StIdle, StHold: begin
            if (win_found) begin
               state_d  = StSetup;
               last_d   = win_idx;
               bank_a_d = req_A[int'(win_idx)*ADDR_W +: ADDR_W];
               bank_d_d = req_D[int'(win_idx)*WIDTH +: WIDTH];
            end else begin
               state_d  = StIdle;
            end
         end
         StSetup:  state_d = StStrobe;
         StStrobe: state_d = StHold;
         default:  state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------
   // State registers. Reset is asynchronous so an in-flight bank_E
   // pulse collapses immediately and the pending write is discarded.
   // ------------------------------------------------------------------
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state_q  <= StIdle;
         last_q   <= LastRst;
         bank_a_q <= '0;
         bank_d_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         bank_a_q <= bank_a_d;
         bank_d_q <= bank_d_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs. All are decoded from registered state, so they are glitch
   // free with respect to req and drop as soon as reset is applied.
   // During SETUP, last_q already holds the winner index.
   // ------------------------------------------------------------------
   always_comb begin
      gnt = '0;
      if (state_q == StSetup) begin
         gnt[last_q] = 1'b1;
      end
   end

   assign bank_E = (state_q == StStrobe);
   assign busy   = (state_q != StIdle);
   assign bank_A = bank_a_q;
   assign bank_D = bank_d_q;

   // ------------------------------------------------------------------
   // Structural properties (ignored by synthesis).
   // ------------------------------------------------------------------
   a_gnt_onehot : assert property (@(posedge C) disable iff (R) $onehot0(gnt));
   a_gnt_not_e  : assert property (@(posedge C) disable iff (R) !(|gnt && bank_E));
   a_e_after_g  : assert property (@(posedge C) disable iff (R) (|gnt) |=> bank_E);

endmodule
